// File: rtl/keypoint_collector.sv
// Collects keypoints from the two per-scale SRAMs, drops those too near the image edge and
// streams the survivors as {scale,row,col} through a 2-entry FIFO to the descriptor stage.
module keypoint_collector #(
    parameter int IMG_ROWS = 480,
    parameter int IMG_COLS = 640,
    parameter int BORDER   = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [11:0] kp1_count,
    input  logic [11:0] kp2_count,
    output logic        kp1_re,
    output logic [10:0] kp1_addr,
    input  logic [18:0] kp1_dout,
    output logic        kp2_re,
    output logic [10:0] kp2_addr,
    input  logic [18:0] kp2_dout,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        out_scale,
    output logic [8:0]  out_row,
    output logic [9:0]  out_col,
    output logic        busy,
    output logic        done,
    output logic [12:0] accepted_count,
    output logic [12:0] rejected_count
);

    localparam logic [8:0] ROW_LO = 9'(BORDER);
    localparam logic [8:0] ROW_HI = 9'(IMG_ROWS - BORDER);
    localparam logic [9:0] COL_LO = 10'(BORDER);
    localparam logic [9:0] COL_HI = 10'(IMG_COLS - BORDER);

    typedef struct packed {
        logic       scale;
        logic [8:0] row;
        logic [9:0] col;
    } kp_t;

    typedef enum logic [2:0] {IDLE, READ1, READ2, DRAIN, DONE} state_t;

    state_t      state;
    logic [11:0] cnt1_q, cnt2_q, issued, issued_nxt, cur_cnt;
    logic [10:0] addr1_q, addr2_q;
    logic        rd_vld, rd_scale;
    kp_t         fifo_mem [2];
    logic        wr_ptr, rd_ptr;
    logic [1:0]  occ;
    logic [2:0]  fill;
    logic        pop, push, reject, issue, credit_ok, reading, last_issue;
    logic [18:0] rd_dout;
    logic [8:0]  rd_row;
    logic [9:0]  rd_col;
    logic        in_border;
    kp_t         head;

    assign head      = fifo_mem[rd_ptr];
    assign out_valid = (occ != 2'd0);
    assign out_scale = head.scale;
    assign out_row   = head.row;
    assign out_col   = head.col;
    assign pop       = out_valid & out_ready;
    assign busy      = (state == READ1) || (state == READ2) || (state == DRAIN);
    assign done      = (state == DONE);
    assign kp1_addr  = addr1_q;
    assign kp2_addr  = addr2_q;

    // Credit counts the entry leaving this cycle as free so a ready consumer sees 1 entry/cycle.
    assign fill      = {1'b0, occ} - {2'b0, pop} + {2'b0, rd_vld};
    assign credit_ok = (fill < 3'd2);

    assign reading    = (state == READ1) || (state == READ2);
    assign cur_cnt    = (state == READ1) ? cnt1_q : cnt2_q;
    assign issue      = reading && (issued != cur_cnt) && credit_ok;
    assign issued_nxt = issued + {11'b0, issue};
    assign last_issue = issue && (issued_nxt == cur_cnt);
    assign kp1_re     = issue && (state == READ1);
    assign kp2_re     = issue && (state == READ2);

    // Return path: data arrives the cycle after re, tagged with the scale that issued it.
    assign rd_dout   = rd_scale ? kp2_dout : kp1_dout;
    assign rd_row    = rd_dout[18:10];
    assign rd_col    = rd_dout[9:0];
    assign in_border = (rd_row >= ROW_LO) && (rd_row < ROW_HI) &&
                       (rd_col >= COL_LO) && (rd_col < COL_HI);
    assign push      = rd_vld & in_border;
    assign reject    = rd_vld & ~in_border;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state          <= IDLE;
            cnt1_q         <= '0;
            cnt2_q         <= '0;
            issued         <= '0;
            addr1_q        <= '0;
            addr2_q        <= '0;
            rd_vld         <= 1'b0;
            rd_scale       <= 1'b0;
            wr_ptr         <= 1'b0;
            rd_ptr         <= 1'b0;
            occ            <= '0;
            accepted_count <= '0;
            rejected_count <= '0;
            for (int i = 0; i < 2; i++) fifo_mem[i] <= '0;
        end else begin
            rd_vld   <= issue;
            rd_scale <= kp2_re;
            if (push) begin
                fifo_mem[wr_ptr] <= '{scale: rd_scale, row: rd_row, col: rd_col};
                wr_ptr           <= ~wr_ptr;
            end
            if (pop) rd_ptr <= ~rd_ptr;
            occ <= occ + {1'b0, push} - {1'b0, pop};
            if (pop)    accepted_count <= accepted_count + 13'd1;
            if (reject) rejected_count <= rejected_count + 13'd1;

            case (state)
                IDLE: if (start) begin
                    cnt1_q         <= kp1_count;
                    cnt2_q         <= kp2_count;
                    issued         <= '0;
                    addr1_q        <= '0;
                    addr2_q        <= '0;
                    accepted_count <= '0;
                    rejected_count <= '0;
                    state          <= READ1;
                end
                READ1: begin
                    if (issue) addr1_q <= last_issue ? 11'd0 : addr1_q + 11'd1;
                    issued <= issued_nxt;
                    if (issued_nxt == cnt1_q) begin
                        issued <= '0;
                        state  <= READ2;
                    end
                end
                READ2: begin
                    if (issue) addr2_q <= last_issue ? 11'd0 : addr2_q + 11'd1;
                    issued <= issued_nxt;
                    if (issued_nxt == cnt2_q) begin
                        issued <= '0;
                        state  <= DRAIN;
                    end
                end
                DRAIN:   if (occ == 2'd0 && !rd_vld) state <= DONE;
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_keypoint_collector.sv
// Directed bench for keypoint_collector: SRAM models, transfer monitor and hand-computed
// expected streams for border, stall, empty and mid-run reset cases.
module tb_keypoint_collector;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [11:0] kp1_count = '0, kp2_count = '0;
    logic        kp1_re, kp2_re;
    logic [10:0] kp1_addr, kp2_addr;
    logic [18:0] kp1_dout = '0, kp2_dout = '0;
    logic        out_valid, out_ready = 1'b1;
    logic        out_scale;
    logic [8:0]  out_row;
    logic [9:0]  out_col;
    logic        busy, done;
    logic [12:0] accepted_count, rejected_count;

    logic [18:0] kp1_mem [0:2047];
    logic [18:0] kp2_mem [0:2047];

    int errors = 0, checks = 0;
    int cyc = 0, start_cyc = 0, mode = 0;
    int nreads = 0, first_re = -1, first_vld = -1, last_xfer = -1;
    logic [31:0] got[$];
    logic [31:0] expq[$];
    logic        prev_stall = 1'b0;
    logic [31:0] held = '0;

    keypoint_collector dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .kp1_count(kp1_count), .kp2_count(kp2_count),
        .kp1_re(kp1_re), .kp1_addr(kp1_addr), .kp1_dout(kp1_dout),
        .kp2_re(kp2_re), .kp2_addr(kp2_addr), .kp2_dout(kp2_dout),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_scale(out_scale), .out_row(out_row), .out_col(out_col),
        .busy(busy), .done(done),
        .accepted_count(accepted_count), .rejected_count(rejected_count)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (kp1_re) kp1_dout <= kp1_mem[kp1_addr];
        if (kp2_re) kp2_dout <= kp2_mem[kp2_addr];
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // Transfer monitor; also holds out_* to their stalled value while valid & !ready.
    always @(posedge clk) begin
        if (rst_n && (kp1_re || kp2_re)) begin
            nreads++;
            if (first_re < 0) first_re = cyc;
        end
        if (rst_n && out_valid && first_vld < 0) first_vld = cyc;
        if (rst_n && prev_stall)
            chk("stall_stable", {12'b0, out_scale, out_row, out_col}, held);
        if (rst_n && out_valid && out_ready) begin
            got.push_back({12'b0, out_scale, out_row, out_col});
            last_xfer = cyc;
        end
        prev_stall = rst_n && out_valid && !out_ready;
        held       = {12'b0, out_scale, out_row, out_col};
    end

    function automatic logic [18:0] m(input int r, input int c);
        return {r[8:0], c[9:0]};
    endfunction

    function automatic logic [31:0] e(input int s, input int r, input int c);
        return {12'b0, s[0], r[8:0], c[9:0]};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        case (mode)
            1:       out_ready = ~out_ready;
            2:       out_ready = 1'b0;
            default: out_ready = 1'b1;
        endcase
    endtask

    task automatic clear_mon();
        got.delete();
        expq.delete();
        nreads = 0; first_re = -1; first_vld = -1; last_xfer = -1;
    endtask

    task automatic start_run(input int n1, input int n2);
        kp1_count = 12'(n1);
        kp2_count = 12'(n2);
        start     = 1'b1;
        start_cyc = cyc;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_done(input int lim, output int dc);
        dc = -1;
        for (int i = 0; i < lim; i++) begin
            if (done) begin
                dc = cyc;
                break;
            end
            tick();
        end
        chk("done_seen", 32'(dc >= 0), 1);
    endtask

    task automatic check_stream(input string tag);
        chk({tag, "_len"}, got.size(), expq.size());
        for (int i = 0; i < expq.size() && i < got.size(); i++)
            chk({tag, "_entry"}, got[i], expq[i]);
    endtask

    task automatic finish_run();
        tick();
        chk("done_pulse", 32'(done), 0);
        chk("busy_after", 32'(busy), 0);
    endtask

    initial begin
        int dc;
        for (int i = 0; i < 2048; i++) begin
            kp1_mem[i] = '0;
            kp2_mem[i] = '0;
        end

        // Reset state
        tick(); tick();
        chk("rst_valid", 32'(out_valid), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_re", 32'({kp1_re, kp2_re}), 0);
        chk("rst_addr", 32'({kp1_addr, kp2_addr}), 0);
        chk("rst_counts", 32'({accepted_count, rejected_count}), 0);
        chk("rst_out", 32'({out_scale, out_row, out_col}), 0);
        rst_n = 1'b1;
        tick();

        // Case 1: three kp1 entries, one below the border
        clear_mon();
        kp1_mem[0] = m(10, 10); kp1_mem[1] = m(20, 30); kp1_mem[2] = m(5, 100);
        expq.push_back(e(0, 10, 10)); expq.push_back(e(0, 20, 30));
        start_run(3, 0);
        chk("c1_busy", 32'(busy), 1);
        wait_done(40, dc);
        chk("c1_re_lat", 32'(first_re - start_cyc), 1);
        chk("c1_vld_lat", 32'(first_vld - start_cyc), 3);
        chk("c1_done_soon", 32'((dc - last_xfer) >= 1 && (dc - last_xfer) <= 3), 1);
        chk("c1_acc", 32'(accepted_count), 2);
        chk("c1_rej", 32'(rejected_count), 1);
        check_stream("c1");
        finish_run();

        // Case 2: both SRAMs empty
        clear_mon();
        start_run(0, 0);
        wait_done(10, dc);
        chk("c2_reads", nreads, 0);
        chk("c2_done_le5", 32'((dc - start_cyc) <= 5), 1);
        chk("c2_counts", 32'({accepted_count, rejected_count}), 0);
        finish_run();

        // Case 3: 4+4 in-border entries, out_ready toggling
        clear_mon();
        for (int i = 0; i < 4; i++) begin
            kp1_mem[i] = m(10 + i, 10 + 10 * i);
            kp2_mem[i] = m(100 + i, 200 + i);
        end
        for (int i = 0; i < 4; i++) expq.push_back(e(0, 10 + i, 10 + 10 * i));
        for (int i = 0; i < 4; i++) expq.push_back(e(1, 100 + i, 200 + i));
        mode = 1;
        start_run(4, 4);
        wait_done(80, dc);
        chk("c3_acc", 32'(accepted_count), 8);
        chk("c3_rej", 32'(rejected_count), 0);
        check_stream("c3");
        mode = 0;
        finish_run();

        // Case 4: border edges
        clear_mon();
        kp1_mem[0] = m(8, 8);   kp1_mem[1] = m(471, 631); kp1_mem[2] = m(7, 50);
        kp1_mem[3] = m(472, 50); kp1_mem[4] = m(50, 632);
        expq.push_back(e(0, 8, 8)); expq.push_back(e(0, 471, 631));
        start_run(5, 0);
        wait_done(40, dc);
        chk("c4_acc", 32'(accepted_count), 2);
        chk("c4_rej", 32'(rejected_count), 3);
        check_stream("c4");
        finish_run();

        // Case 5: consumer stalled for 20 cycles
        clear_mon();
        for (int i = 0; i < 4; i++) kp1_mem[i] = m(30 + i, 40 + i);
        for (int i = 0; i < 4; i++) expq.push_back(e(0, 30 + i, 40 + i));
        mode = 2;
        out_ready = 1'b0;
        start_run(4, 0);
        for (int i = 0; i < 20; i++) tick();
        chk("c5_reads_stalled", nreads, 2);
        chk("c5_valid_stalled", 32'(out_valid), 1);
        chk("c5_none_out", got.size(), 0);
        mode = 0;
        tick();
        wait_done(40, dc);
        chk("c5_acc", 32'(accepted_count), 4);
        check_stream("c5");
        finish_run();

        // Case 6: reset in the middle of READ2, then a clean run
        clear_mon();
        for (int i = 0; i < 4; i++) begin
            kp1_mem[i] = m(60 + i, 70 + i);
            kp2_mem[i] = m(80 + i, 90 + i);
        end
        start_run(2, 4);
        for (int i = 0; i < 30; i++) begin
            if (kp2_re) break;
            tick();
        end
        chk("c6_in_read2", 32'(kp2_re), 1);
        rst_n = 1'b0;
        tick();
        chk("c6_rst_busy", 32'(busy), 0);
        chk("c6_rst_valid", 32'(out_valid), 0);
        chk("c6_rst_re", 32'({kp1_re, kp2_re}), 0);
        chk("c6_rst_addr", 32'({kp1_addr, kp2_addr}), 0);
        chk("c6_rst_counts", 32'({accepted_count, rejected_count}), 0);
        rst_n = 1'b1;
        tick();
        clear_mon();
        expq.push_back(e(0, 60, 70)); expq.push_back(e(1, 80, 90));
        start_run(1, 1);
        wait_done(40, dc);
        chk("c6_acc", 32'(accepted_count), 2);
        chk("c6_rej", 32'(rejected_count), 0);
        check_stream("c6");
        finish_run();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
